// File: rtl/cfu_pkg.sv
// ---------------------------------------------------------------------------
// cfu_pkg
// Shared definitions for the CFU output path: default int8 activation clamp
// bounds, the legal requantisation shift window and the accumulator type.
// No ports (package).
// ---------------------------------------------------------------------------
package cfu_pkg;

    localparam int ACT_MIN_DEFAULT = -128;
    localparam int ACT_MAX_DEFAULT = 127;

    // Keeps 30-shift and 31-shift inside 0..63 so the 64-bit datapath never
    // shifts out of range.
    localparam logic signed [7:0] SHIFT_MIN = -8'sd32;
    localparam logic signed [7:0] SHIFT_MAX = 8'sd30;

    typedef logic signed [31:0] acc_t;

    function automatic logic signed [7:0] clamp_shift(input logic signed [7:0] s);
        logic signed [7:0] r;
        r = s;
        if (s < SHIFT_MIN) begin
            r = SHIFT_MIN;
        end else if (s > SHIFT_MAX) begin
            r = SHIFT_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/requant_core.sv
// ---------------------------------------------------------------------------
// requant_core
// Four-stage requantisation pipeline, all stages advance together on en_i.
//   S1: sum  = acc + bias                           (32-bit wrap)
//   S2: prod = sum * mult + (1 << (30 - shift))     (signed 64-bit)
//   S3: res  = (prod >>> (31 - shift))[31:0] + offset
//   S4: res clamped to [ACT_MIN, ACT_MAX], held as one int8 byte
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   en_i                  global advance enable
//   in_valid_i/last_i     sideband of the word entering S1
//   in_acc_i              accumulator entering S1
//   bias_i..shift_i       requantisation parameters (shift already clamped)
//   busy_o                any of S1..S3 holds a valid item
//   out_valid_o/last_o    S4 sideband
//   out_byte_o            S4 clamped int8 result
// ---------------------------------------------------------------------------
module requant_core
    import cfu_pkg::*;
#(
    parameter int ACT_MIN = ACT_MIN_DEFAULT,
    parameter int ACT_MAX = ACT_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    input  acc_t              in_acc_i,
    input  acc_t              bias_i,
    input  acc_t              mult_i,
    input  acc_t              offset_i,
    input  logic signed [7:0] shift_i,
    output logic              busy_o,
    output logic              out_valid_o,
    output logic              out_last_o,
    output logic [7:0]        out_byte_o
);

    logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    acc_t              s1_sum_q, s1_sum_d;
    logic              s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic signed [63:0] s2_prod_q, s2_prod_d;
    logic              s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
    acc_t              s3_res_q, s3_res_d;
    logic              s4_valid_q, s4_valid_d, s4_last_q, s4_last_d;
    logic [7:0]        s4_byte_q, s4_byte_d;

    logic signed [63:0] sum_ext, mult_ext;
    logic [5:0]         rnd_sh, res_sh;
    logic [7:0]         clamped;

    always_comb begin
        sum_ext  = {{32{s1_sum_q[31]}}, s1_sum_q};
        mult_ext = {{32{mult_i[31]}}, mult_i};
        // shift_i is pre-clamped to -32..30, so both amounts fit in 6 bits
        rnd_sh   = 6'(8'sd30 - shift_i);
        res_sh   = 6'(8'sd31 - shift_i);

        if (s3_res_q < acc_t'(ACT_MIN)) begin
            clamped = 8'(ACT_MIN);
        end else if (s3_res_q > acc_t'(ACT_MAX)) begin
            clamped = 8'(ACT_MAX);
        end else begin
            clamped = s3_res_q[7:0];
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_sum_d   = s1_sum_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_prod_d  = s2_prod_q;
        s3_valid_d = s3_valid_q;
        s3_last_d  = s3_last_q;
        s3_res_d   = s3_res_q;
        s4_valid_d = s4_valid_q;
        s4_last_d  = s4_last_q;
        s4_byte_d  = s4_byte_q;
        if (en_i) begin
            s1_valid_d = in_valid_i;
            s1_last_d  = in_last_i;
            s1_sum_d   = in_acc_i + bias_i;
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_prod_d  = sum_ext * mult_ext + (64'sd1 <<< rnd_sh);
            s3_valid_d = s2_valid_q;
            s3_last_d  = s2_last_q;
            s3_res_d   = acc_t'(s2_prod_q >>> res_sh) + offset_i;
            s4_valid_d = s3_valid_q;
            s4_last_d  = s3_last_q;
            s4_byte_d  = clamped;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
            s3_res_q   <= '0;
            s4_valid_q <= 1'b0;
            s4_last_q  <= 1'b0;
            s4_byte_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_prod_q  <= s2_prod_d;
            s3_valid_q <= s3_valid_d;
            s3_last_q  <= s3_last_d;
            s3_res_q   <= s3_res_d;
            s4_valid_q <= s4_valid_d;
            s4_last_q  <= s4_last_d;
            s4_byte_q  <= s4_byte_d;
        end
    end

    assign busy_o      = s1_valid_q | s2_valid_q | s3_valid_q;
    assign out_valid_o = s4_valid_q;
    assign out_last_o  = s4_last_q;
    assign out_byte_o  = s4_byte_q;

endmodule

// File: rtl/requant_pack.sv
// ---------------------------------------------------------------------------
// requant_pack
// Requantises int32 accumulators to int8 and packs four results per 32-bit
// word (first result in [7:0]). A row end (in_last) flushes a partial word.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cfg_we, cfg_ready            config write strobe / safe-to-write status
//   cfg_bias, cfg_offset         signed bias and output zero-point
//   cfg_multiplier, cfg_shift    Q31 multiplier and signed shift (clamped)
//   in_valid, in_ready           accumulator handshake
//   in_acc, in_last              accumulator and end-of-row flag
//   out_valid, out_ready         packed word handshake
//   out_data, out_bytes          packed word and its count of valid bytes
// ---------------------------------------------------------------------------
module requant_pack
    import cfu_pkg::*;
#(
    parameter int ACT_MIN = ACT_MIN_DEFAULT,
    parameter int ACT_MAX = ACT_MAX_DEFAULT,
    parameter int LANES   = 4  // only 4 is supported
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_we,
    output logic        cfg_ready,
    input  logic [31:0] cfg_bias,
    input  logic [31:0] cfg_offset,
    input  logic [31:0] cfg_multiplier,
    input  logic [7:0]  cfg_shift,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_acc,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes
);

    logic en, cfg_load, core_busy;
    logic s4_valid, s4_last;
    logic [7:0] s4_byte;

    acc_t              bias_q, bias_d, offset_q, offset_d, mult_q, mult_d, bias_eff;
    logic signed [7:0] shift_q, shift_d;

    logic [2:0]  cnt_q, cnt_d, cnt_inc;
    logic [31:0] pack_q, pack_d, word;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [2:0]  out_bytes_q, out_bytes_d;

    assign en        = ~out_valid_q | out_ready;
    assign in_ready  = en;
    assign cfg_ready = ~core_busy;
    assign cfg_load  = cfg_we & cfg_ready;

    // An input accepted in the same cycle as a config write must see the new
    // bias; later stages read the registers, which are updated by then.
    assign bias_eff = cfg_load ? acc_t'(cfg_bias) : bias_q;

    always_comb begin
        bias_d   = bias_q;
        offset_d = offset_q;
        mult_d   = mult_q;
        shift_d  = shift_q;
        if (cfg_load) begin
            bias_d   = acc_t'(cfg_bias);
            offset_d = acc_t'(cfg_offset);
            mult_d   = acc_t'(cfg_multiplier);
            shift_d  = clamp_shift($signed(cfg_shift));
        end
    end

    requant_core #(
        .ACT_MIN(ACT_MIN),
        .ACT_MAX(ACT_MAX)
    ) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (en),
        .in_valid_i (in_valid),
        .in_last_i  (in_last),
        .in_acc_i   (acc_t'(in_acc)),
        .bias_i     (bias_eff),
        .mult_i     (mult_q),
        .offset_i   (offset_q),
        .shift_i    (shift_q),
        .busy_o     (core_busy),
        .out_valid_o(s4_valid),
        .out_last_o (s4_last),
        .out_byte_o (s4_byte)
    );

    always_comb begin
        cnt_d       = cnt_q;
        pack_d      = pack_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        cnt_inc     = cnt_q + 3'd1;
        word        = pack_q;
        word[{cnt_q[1:0], 3'b000} +: 8] = s4_byte;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // en also covers the emit: a held word blocks the packer entirely,
        // while a consumed word is replaced in the same cycle.
        if (en && s4_valid) begin
            if (cnt_inc == 3'(LANES) || s4_last) begin
                out_valid_d = 1'b1;
                out_data_d  = word;
                out_bytes_d = cnt_inc;
                cnt_d       = 3'd0;
                pack_d      = '0;
            end else begin
                pack_d = word;
                cnt_d  = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bias_q      <= '0;
            offset_q    <= '0;
            mult_q      <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            pack_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
        end else begin
            bias_q      <= bias_d;
            offset_q    <= offset_d;
            mult_q      <= mult_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            pack_q      <= pack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bytes = out_bytes_q;

endmodule

// File: tb/tb_requant_pack.sv
// ---------------------------------------------------------------------------
// tb_requant_pack
// Scoreboard bench for requant_pack: stimulus pushes expected words, a
// negedge monitor pops and compares on every output handshake and checks
// that a stalled word holds steady.
// ---------------------------------------------------------------------------
module tb_requant_pack;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_bias = '0, cfg_offset = '0, cfg_multiplier = '0;
    logic [7:0]  cfg_shift = '0;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic        in_ready;
    logic [31:0] in_acc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;

    always #5 clk = ~clk;

    requant_pack dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_we        (cfg_we),
        .cfg_ready     (cfg_ready),
        .cfg_bias      (cfg_bias),
        .cfg_offset    (cfg_offset),
        .cfg_multiplier(cfg_multiplier),
        .cfg_shift     (cfg_shift),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_acc        (in_acc),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_bytes     (out_bytes)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bytes;
    } word_t;
    word_t exp_q[$];

    // Reference model state: the config the DUT should be using and the
    // int8 results collected since the last emitted word.
    int         m_bias = 0, m_offset = 0, m_mult = 0, m_shift = 0;
    logic [7:0] m_pend[$];
    bit         model_on = 1'b0;
    bit         rand_ready = 1'b0;
    bit         saw_in_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int acc);
        int     sum, sh, r;
        longint prod, q;
        sum = acc + m_bias;
        sh  = m_shift;
        if (sh < -32) sh = -32;
        if (sh > 30) sh = 30;
        prod = longint'(sum) * longint'(m_mult) + (longint'(1) <<< (30 - sh));
        q    = prod >>> (31 - sh);
        r    = int'(q) + m_offset;
        if (r < -128) r = -128;
        if (r > 127) r = 127;
        return 8'(r);
    endfunction

    task automatic exp_push(input logic [31:0] d, input logic [2:0] b);
        word_t w;
        w.data  = d;
        w.bytes = b;
        exp_q.push_back(w);
    endtask

    task automatic model_accept(input logic [31:0] acc, input logic last);
        word_t w;
        if (!model_on) return;
        m_pend.push_back(ref_byte(int'(acc)));
        if (m_pend.size() == 4 || last) begin
            w.data  = '0;
            w.bytes = 3'(m_pend.size());
            for (int i = 0; i < m_pend.size(); i++) w.data[8*i +: 8] = m_pend[i];
            exp_q.push_back(w);
            m_pend.delete();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [31:0] acc, input logic last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_acc   = acc;
        in_last  = last;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            model_accept(acc, last);
        end else begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for 300 cycles want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // One-cycle config write, optionally with an input in the same cycle.
    task automatic cfg_send(input int b, input int o, input int m, input logic [7:0] s,
                            input bit with_in, input logic [31:0] acc, input logic last,
                            output bit took);
        bit acc_ok;
        acc_ok         = 1'b0;
        cfg_we         = 1'b1;
        cfg_bias       = b;
        cfg_offset     = o;
        cfg_multiplier = m;
        cfg_shift      = s;
        if (with_in) begin
            in_valid = 1'b1;
            in_acc   = acc;
            in_last  = last;
        end
        @(negedge clk);
        took = cfg_ready;
        if (took) begin
            m_bias   = b;
            m_offset = o;
            m_mult   = m;
            m_shift  = int'($signed(s));
        end
        if (with_in && in_ready) begin
            model_accept(acc, last);
            acc_ok = 1'b1;
        end
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (with_in && !acc_ok) send(acc, last);
    endtask

    task automatic cfg(input int b, input int o, input int m, input logic [7:0] s);
        bit took;
        cfg_send(b, o, m, s, 1'b0, 32'd0, 1'b0, took);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cfg_ready || out_valid) && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d words outstanding want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake happens at the next posedge when both are high.
    word_t       mon_w;
    logic [31:0] held_data;
    logic [2:0]  held_bytes;
    bit          held_valid = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_data", out_data, held_data);
                check("hold_bytes", {29'b0, out_bytes}, {29'b0, held_bytes});
            end
            held_valid = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: got 0x%08h/%0d want no word",
                                 out_data, out_bytes);
                    end else begin
                        mon_w = exp_q.pop_front();
                        check("word_data", out_data, mon_w.data);
                        check("word_bytes", {29'b0, out_bytes}, {29'b0, mon_w.bytes});
                    end
                end else begin
                    held_data  = out_data;
                    held_bytes = out_bytes;
                    held_valid = 1'b1;
                end
            end
            if (!in_ready) saw_in_stall = 1'b1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 9) < 6);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000 want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit took;
        int acc_r;

        // Reset state
        idle(2);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_bytes", {29'b0, out_bytes}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
        reset_n = 1'b1;
        idle(2);

        // 1: single result with last
        cfg(28, -128, 32'h4000_0000, 8'd0);
        exp_push(32'h0000_00C0, 3'd1);
        send(32'd100, 1'b1);
        drain("t1");

        // 2: four back-to-back results make one full word
        cfg(0, 0, 32'h4000_0000, 8'd1);
        exp_push(32'h0403_0201, 3'd4);
        for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
        drain("t2");

        // 3: saturation at both ends
        cfg(0, 0, 32'h7FFF_FFFF, 8'd0);
        exp_push(32'h0000_807F, 3'd2);
        send(32'd1000000, 1'b0);
        send(-32'sd1000000, 1'b1);
        drain("t3");

        // 4: output back-pressure during a 12-input stream
        cfg(0, 0, 32'h4000_0000, 8'd1);
        exp_push(32'h0403_0201, 3'd4);
        exp_push(32'h0807_0605, 3'd4);
        exp_push(32'h0C0B_0A09, 3'd4);
        saw_in_stall = 1'b0;
        fork
            begin
                for (int i = 1; i <= 12; i++) send(32'(i), 1'b0);
            end
            begin
                idle(7);
                out_ready = 1'b0;
                idle(10);
                out_ready = 1'b1;
            end
        join
        drain("t4");
        check("t4_in_ready_dropped", {31'b0, saw_in_stall}, 32'd1);

        // 5: config write while busy is ignored, when idle it applies
        exp_push(32'h0000_000A, 3'd1);
        send(32'd10, 1'b1);
        cfg_send(0, 0, 32'h2000_0000, 8'd1, 1'b0, 32'd0, 1'b0, took);
        check("t5_busy_cfg_ignored", {31'b0, took}, 32'd0);
        drain("t5a");
        cfg_send(0, 0, 32'h2000_0000, 8'd1, 1'b0, 32'd0, 1'b0, took);
        check("t5_idle_cfg_taken", {31'b0, took}, 32'd1);
        exp_push(32'h0000_0005, 3'd1);
        send(32'd10, 1'b1);
        drain("t5b");
        // same-cycle config and input: the input sees the new bias
        exp_push(32'h0000_000F, 3'd1);
        cfg_send(5, 0, 32'h4000_0000, 8'd1, 1'b1, 32'd10, 1'b1, took);
        drain("t5c");

        // 6: reset with 2 bytes packed and 2 in flight
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        idle(2);
        send(32'd3, 1'b0);
        send(32'd4, 1'b0);
        check("t6_busy_before_rst", {31'b0, cfg_ready}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("t6_out_valid", {31'b0, out_valid}, 32'd0);
        check("t6_out_data", out_data, 32'd0);
        check("t6_out_bytes", {29'b0, out_bytes}, 32'd0);
        check("t6_cfg_ready", {31'b0, cfg_ready}, 32'd1);
        exp_q.delete();
        m_pend.delete();
        m_bias   = 0;
        m_offset = 0;
        m_mult   = 0;
        m_shift  = 0;
        idle(2);
        reset_n = 1'b1;
        idle(2);
        cfg(0, 0, 32'h4000_0000, 8'd1);
        exp_push(32'h0000_0021, 3'd1);
        send(32'h21, 1'b1);
        idle(20);
        drain("t6");

        // Randomised traffic against the model
        model_on   = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i % 25 == 0 || $urandom_range(0, 40) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    cfg_send(int'($urandom()), int'($urandom()), int'($urandom()),
                             8'($urandom()), 1'b0, 32'd0, 1'b0, took);
                end else begin
                    acc_r = $urandom_range(0, 4000) - 2000;
                    cfg_send($urandom_range(0, 200) - 100, $urandom_range(0, 60) - 30,
                             int'($urandom_range(32'h2000_0000, 32'h7FFF_FFFF)),
                             8'($urandom_range(0, 9) - 8), $urandom_range(0, 1) == 1,
                             32'(acc_r), $urandom_range(0, 7) == 0, took);
                end
            end
            acc_r = $urandom_range(0, 4000) - 2000;
            send(32'(acc_r), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        send(32'd0, 1'b1);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
